// File: rtl/wombat_regbank_pkg.sv
// Shared constants and FSM encodings for the wombat AXI4-Lite register bank.
package wombat_regbank_pkg;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] READ_UNMAPPED = 32'hDEADBEEF;

    // RO window starts at 1 << OFFSET_MSB; anything above bit OFFSET_MSB is unmapped.
    localparam int unsigned RO_OFFSET  = 'h400;
    localparam int unsigned OFFSET_MSB = 10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/wombat_regbank_decode.sv
// Combinational byte-offset decode into RW / RO / unmapped plus 8-bit register index.
// Purely combinational; used by both the write and the read channel.
module wombat_regbank_decode
    import wombat_regbank_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NUM_RW = 4,
    parameter int unsigned NUM_RO = 4
) (
    input  logic [ADDR_W-1:0] offset_i,
    output logic              is_rw_o,
    output logic              is_ro_o,
    output logic [7:0]        index_o,
    output logic              unmapped_o
);

    logic       high_clear;
    logic [8:0] idx_ext;
    logic       unused_low_bits;

    generate
        if (ADDR_W > OFFSET_MSB + 1) begin : g_high
            assign high_clear = ~|offset_i[ADDR_W-1:OFFSET_MSB+1];
        end else begin : g_no_high
            assign high_clear = 1'b1;
        end
    endgenerate

    assign index_o    = offset_i[OFFSET_MSB-1:2];
    assign idx_ext    = {1'b0, index_o};
    assign is_rw_o    = high_clear && !offset_i[OFFSET_MSB] && (idx_ext < 9'(NUM_RW));
    assign is_ro_o    = high_clear &&  offset_i[OFFSET_MSB] && (idx_ext < 9'(NUM_RO));
    assign unmapped_o = !(is_rw_o || is_ro_o);

    // Sub-word byte offset carries no meaning for 32-bit registers.
    assign unused_low_bits = ^offset_i[1:0];

endmodule

// File: rtl/wombat_axil_regbank.sv
// AXI4-Lite bank of RW control and RO status registers with optional clear-on-read.
// Write/read responses one cycle after the last handshake; B/R stalls hold the channel busy.
module wombat_axil_regbank
    import wombat_regbank_pkg::*;
#(
    parameter logic [31:0]            C_BASE_ADDRESS     = 32'h0000_0000,
    parameter int unsigned            C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned            C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned            C_NUM_RW           = 4,
    parameter int unsigned            C_NUM_RO           = 4,
    parameter logic [255:0]           C_COR_MASK         = '0,
    parameter logic [32*C_NUM_RW-1:0] C_RW_DEFAULT       = '0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*C_NUM_RW-1:0]          rw_regs,
    output logic [C_NUM_RW-1:0]             rw_wr_pulse,
    input  logic [32*C_NUM_RO-1:0]          ro_regs,
    output logic [C_NUM_RO-1:0]             ro_rd_clear
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [AW-1:0] BASE = AW'(C_BASE_ADDRESS);

    generate
        if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("wombat_axil_regbank: C_S_AXI_DATA_WIDTH must be 32");
        end
        if (C_NUM_RW < 1 || C_NUM_RW > 256) begin : g_bad_num_rw
            $error("wombat_axil_regbank: C_NUM_RW must be 1..256");
        end
        if (C_NUM_RO < 1 || C_NUM_RO > 256) begin : g_bad_num_ro
            $error("wombat_axil_regbank: C_NUM_RO must be 1..256");
        end
        if (AW < OFFSET_MSB + 1) begin : g_bad_addr_width
            $error("wombat_axil_regbank: address too narrow for the register map");
        end
    endgenerate

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    // Holds readies low for the first edge after reset release.
    logic                ready_en_q;
    logic                aw_held_q, w_held_q;
    logic [AW-1:0]       awaddr_q;
    logic [31:0]         wdata_q;
    logic [SW-1:0]       wstrb_q;

    logic [31:0]         rw_q [C_NUM_RW];
    logic [31:0]         rw_d [C_NUM_RW];
    logic [C_NUM_RW-1:0] wr_pulse_q, wr_pulse_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;
    logic [C_NUM_RO-1:0] rd_clear_q, rd_clear_d;

    logic          aw_hs, w_hs, ar_hs, wr_go;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [SW-1:0] wr_strb;
    logic          wr_is_rw, wr_is_ro, wr_unmapped;
    logic [7:0]    wr_index;
    logic          rd_is_rw, rd_is_ro, rd_unmapped;
    logic [7:0]    rd_index;
    logic [31:0]   rd_val;
    logic [1:0]    rd_resp;

    // ---------------- write channel ----------------
    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign wr_go   = (wr_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

    wombat_regbank_decode #(.ADDR_W(AW), .NUM_RW(C_NUM_RW), .NUM_RO(C_NUM_RO)) u_wr_dec (
        .offset_i   (wr_addr ^ BASE),
        .is_rw_o    (wr_is_rw),
        .is_ro_o    (wr_is_ro),
        .index_o    (wr_index),
        .unmapped_o (wr_unmapped)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (wr_go) wr_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = ready_en_q && (wr_state_q == W_IDLE) && !aw_held_q;
        S_AXI_WREADY  = ready_en_q && (wr_state_q == W_IDLE) && !w_held_q;
        S_AXI_BVALID  = (wr_state_q == W_RESP);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (wr_go) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end
        end
    end

    // Write pulse fires for any mapped RW write, even with an all-zero strobe.
    always_comb begin
        rw_d       = rw_q;
        wr_pulse_d = '0;
        bresp_d    = bresp_q;
        if (wr_go) begin
            bresp_d = (wr_unmapped || wr_is_ro) ? RESP_SLVERR : RESP_OKAY;
            if (wr_is_rw) begin
                for (int i = 0; i < C_NUM_RW; i++) begin
                    if (wr_index == 8'(i)) begin
                        wr_pulse_d[i] = 1'b1;
                        for (int b = 0; b < SW; b++) begin
                            if (wr_strb[b]) rw_d[i][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < C_NUM_RW; i++) rw_q[i] <= C_RW_DEFAULT[32*i +: 32];
            wr_pulse_q <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            rw_q       <= rw_d;
            wr_pulse_q <= wr_pulse_d;
            bresp_q    <= bresp_d;
        end
    end

    // ---------------- read channel ----------------
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    wombat_regbank_decode #(.ADDR_W(AW), .NUM_RW(C_NUM_RW), .NUM_RO(C_NUM_RO)) u_rd_dec (
        .offset_i   (S_AXI_ARADDR ^ BASE),
        .is_rw_o    (rd_is_rw),
        .is_ro_o    (rd_is_ro),
        .index_o    (rd_index),
        .unmapped_o (rd_unmapped)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = ready_en_q && (rd_state_q == R_IDLE);
        S_AXI_RVALID  = (rd_state_q == R_DATA);
    end

    // Reads of RW return the pre-write value when a write lands on the same edge.
    always_comb begin
        rd_val     = READ_UNMAPPED;
        rd_resp    = rd_unmapped ? RESP_SLVERR : RESP_OKAY;
        rd_clear_d = '0;
        for (int i = 0; i < C_NUM_RW; i++) begin
            if (rd_is_rw && rd_index == 8'(i)) rd_val = rw_q[i];
        end
        for (int j = 0; j < C_NUM_RO; j++) begin
            if (rd_is_ro && rd_index == 8'(j)) begin
                rd_val        = ro_regs[32*j +: 32];
                rd_clear_d[j] = ar_hs && C_COR_MASK[j];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_clear_q <= '0;
        end else begin
            rd_clear_q <= rd_clear_d;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_resp;
            end
        end
    end

    generate
        for (genvar i = 0; i < C_NUM_RW; i++) begin : g_rw_out
            assign rw_regs[32*i +: 32] = rw_q[i];
        end
    endgenerate

    assign rw_wr_pulse = wr_pulse_q;
    assign ro_rd_clear = rd_clear_q;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

endmodule
